keypad_scan_ctrl: RTL and testbench

- Scans the 4x4 calculator keypad by driving one column at a time and sampling the row returns.
- Debounces the sampled key and encodes it to a 4-bit key code.
- Emits one key_valid pulse per debounced press, consumed by the calculator input stage.
- Sits between the physical keypad (modelled in the testbench) and the calculator core.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_scan_frame.sv | 68 ++++++
 rtl/keypad_scan_ctrl.sv | 105 ++++++++++
 tb/tb_keypad_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, FSM state and frame-result types for the keypad scanner
package keypad_pkg;
  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_EQ    = 4'd14;
  localparam logic [3:0] KEY_CLR   = 4'd15;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;
  function automatic logic [3:0] key_encode(input int rows, input int r, input int c);
    return 4'(4 * (rows - 1 - r) + c);
  endfunction
endpackage

// File: rtl/keypad_scan_frame.sv
// keypad_scan_frame: column drive, dwell timing and per-frame row accumulation
module keypad_scan_frame
  import keypad_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_en,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            frame_done,
  output frame_t          frame_result,
  output logic [3:0]      frame_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CLAST = CW'(COLS - 1);
  logic [DW-1:0] dwell;
  logic [CW-1:0] ci;
  logic [1:0] hits, tot;
  logic [3:0] acc_code, code_now;
  logic last;
  int r_idx, ones;
  assign last = dwell == DLAST;
  // locate the returning row, count bits seen this frame (saturating at two)
  always_comb begin
    r_idx = 0;
    for (int r = 0; r < ROWS; r++) if (row[r]) r_idx = r;
    ones = $countones(row);
    tot = (int'(hits) + ones > 1) ? 2'd2 : 2'(int'(hits) + ones);
    code_now = key_encode(ROWS, r_idx, int'(ci));
  end
  // dwell/column sequencing; rows sampled only at the last dwell cycle of each column
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= COLS'(1);
      dwell <= '0;
      ci <= '0;
      hits <= '0;
      acc_code <= '0;
      frame_done <= 1'b0;
      frame_result <= NONE;
      frame_code <= '0;
    end else if (!scan_en || col == '0) begin
      col <= scan_en ? COLS'(1) : '0;
      dwell <= '0;
      ci <= '0;
      hits <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last && ci == CLAST;
      dwell <= last ? '0 : dwell + 1'b1;
      if (last) begin
        col <= {col[COLS-2:0], col[COLS-1]};
        ci <= ci == CLAST ? '0 : ci + 1'b1;
        hits <= ci == CLAST ? '0 : tot;
        if (ones == 1) acc_code <= code_now;
        if (ci == CLAST) begin
          frame_result <= tot == 2'd0 ? NONE : tot == 2'd1 ? SINGLE : MULTI;
          frame_code <= ones == 1 ? code_now : acc_code;
        end
      end
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: keypad scan, debounce and key_valid generation; KEYPAD_AUTOREPEAT_EN adds held-key repeats
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_en,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);
  localparam logic [7:0] DS = 8'(DEBOUNCE_SCANS);
  state_t state, state_n;
  frame_t frame_result;
  logic frame_done, single, match_k, accept;
  logic [3:0] frame_code, cand, cand_n;
  logic [7:0] cnt, cnt_n, rel, rel_n;
  keypad_scan_frame #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV)) u_frame (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .row(row),
    .col(col),
    .frame_done(frame_done),
    .frame_result(frame_result),
    .frame_code(frame_code)
  );
  assign single = frame_result == SINGLE;
  assign match_k = single && frame_code == key_code;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [3:0] rep;
  logic fire;
  assign fire = frame_done && state == HELD && match_k && rep == 4'd7;
  // matching held frames: first repeat after 8, then every 4; any other frame restarts the count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rep <= '0;
    else rep <= (!scan_en || state != HELD || (frame_done && !match_k)) ? '0 :
                frame_done ? (fire ? 4'd4 : rep + 4'd1) : rep;
`else
  logic fire;
  assign fire = 1'b0;
`endif
  // state and output registers; scan_en low forces idle but keeps key_code and a due pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SCAN;
      cand <= '0;
      cnt <= '0;
      rel <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= scan_en ? state_n : SCAN;
      cnt <= scan_en ? cnt_n : '0;
      rel <= scan_en ? rel_n : '0;
      cand <= cand_n;
      key_code <= accept ? cand_n : key_code;
      key_valid <= accept | fire;
    end
  // debounce/held transitions, evaluated only when a frame result arrives
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    rel_n = rel;
    accept = 1'b0;
    if (frame_done)
      case (state)
        SCAN:
          if (single) begin
            cand_n = frame_code;
            cnt_n = 8'd1;
            accept = DS == 8'd1;
            state_n = DEBOUNCE;
          end
        DEBOUNCE:
          if (single && frame_code == cand) begin
            cnt_n = cnt + 8'd1;
            accept = cnt_n == DS;
          end else begin
            state_n = SCAN;
            cnt_n = '0;
          end
        HELD: begin
          rel_n = match_k ? '0 : rel + 8'd1;
          state_n = rel_n == DS ? SCAN : HELD;
        end
        default: state_n = SCAN;
      endcase
    if (accept) begin
      state_n = HELD;
      rel_n = '0;
      cnt_n = '0;
    end
  end
  // held level follows the FSM
  always_comb key_held = state == HELD;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad model, per-cycle reference model compare and directed pulse-timing checks
module tb_keypad_scan_ctrl;
  localparam int COLS = 4, ROWS = 4, SD = 4, DS = 3;
  logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b1;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [3:0] key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int vectors = 0, errors = 0;
  int cyc = 0;
  bit held_seen;
  int pulses[$], codes[$], exp_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // physical keypad: a pressed key code k connects column k%4 to row 3-k/4
  always_comb begin
    row = '0;
    for (int k = 0; k < 16; k++) if (keys[k] && col[k % COLS]) row[ROWS - 1 - k / COLS] = 1'b1;
  end

  // reference model: scan position in cycles, frame classification by counting pressed keys seen,
  // then streak counting of identical frames for press and release
  bit m_idle, m_fd, m_held, m_valid;
  int m_pos, m_nseen, m_scode, m_fr, m_fc, m_streak, m_cand, m_rel, m_rep, m_code;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_idle = 0; m_fd = 0; m_held = 0; m_valid = 0;
      m_pos = 0; m_nseen = 0; m_scode = 0; m_fr = 0; m_fc = 0;
      m_streak = 0; m_cand = 0; m_rel = 0; m_rep = 0; m_code = 0;
    end else begin
      m_valid = 0;
      if (m_fd) begin
        if (!m_held) begin
          if (m_streak == 0) begin
            if (m_fr == 1) begin m_cand = m_fc; m_streak = 1; end
          end else m_streak = (m_fr == 1 && m_fc == m_cand) ? m_streak + 1 : 0;
          if (m_streak == DS) begin
            m_code = m_cand; m_valid = 1; m_held = 1; m_rel = 0; m_rep = 0; m_streak = 0;
          end
        end else if (m_fr == 1 && m_fc == m_code) begin
          m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
          m_rep++;
          if (m_rep == 8) begin m_valid = 1; m_rep = 4; end
`endif
        end else begin
          m_rel++; m_rep = 0;
          if (m_rel == DS) m_held = 0;
        end
      end
      if (!scan_en) begin m_held = 0; m_streak = 0; m_rel = 0; m_rep = 0; end
      m_fd = 0;
      if (!scan_en) m_idle = 1;
      else if (m_idle) begin m_idle = 0; m_pos = 0; m_nseen = 0; end
      else begin
        if (m_pos % SD == SD - 1) begin
          for (int k = 0; k < 16; k++)
            if (keys[k] && k % COLS == m_pos / SD) begin m_nseen++; m_scode = k; end
          if (m_pos / SD == COLS - 1) begin
            m_fd = 1;
            m_fr = m_nseen == 0 ? 0 : m_nseen == 1 ? 1 : 2;
            m_fc = m_scode;
            m_nseen = 0;
          end
        end
        m_pos = (m_pos + 1) % (SD * COLS);
      end
    end
  end

  // every-cycle compare against the model, away from the active edge
  initial forever begin
    logic [COLS-1:0] ec;
    @(negedge clk);
    ec = m_idle ? '0 : COLS'(1 << (m_pos / SD));
    vectors++;
    if (col !== ec || key_valid !== m_valid || key_held !== m_held || key_code !== 4'(m_code)) begin
      errors++;
      $display("FAIL cycle_compare t=%0t dut col=%b valid=%b held=%b code=%0d, model col=%b valid=%b held=%b code=%0d",
               $time, col, key_valid, key_held, key_code, ec, m_valid, m_held, m_code);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_held) held_seen = 1;
      if (key_valid) begin pulses.push_back(cyc); codes.push_back(int'(key_code)); end
    end
  endtask

  task automatic start(input logic [15:0] k);
    rst_n = 1'b0;
    scan_en = 1'b1;
    keys = k;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    held_seen = 0;
    pulses.delete();
    codes.delete();
  endtask

  task automatic check_pulses(input string name, input int code);
    chk({name, "_count"}, pulses.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
      chk({name, "_cycle"}, pulses[i], exp_q[i]);
      chk({name, "_code"}, codes[i], code);
    end
  endtask

  initial begin
    // reset state
    start(16'h0000);
    chk("rst_col", int'(col), 1);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_code", int'(key_code), 0);

    // key 3 held from cycle 0, then released: held drops after three empty frames
    start(16'h0001 << 3);
    run(400);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q = '{49, 177, 241, 305, 369};
`else
    exp_q = '{49};
`endif
    check_pulses("hold3", 3);
    chk("hold3_held", int'(key_held), 1);
    keys = '0;
    run(40);
    chk("rel3_held_at440", int'(key_held), 1);
    run(20);
    chk("rel3_held_at460", int'(key_held), 0);

    // short press never accepted
    start(16'h0001 << 7);
    run(20);
    keys = '0;
    run(130);
    exp_q = {};
    check_pulses("short7", 7);
    chk("short7_held", int'(held_seen), 0);

    // two keys in one column: every frame MULTI
    start((16'h0001 << 2) | (16'h0001 << 10));
    run(150);
    exp_q = {};
    check_pulses("multi", 0);
    chk("multi_held", int'(held_seen), 0);

    // press, release, re-press key 14
    start(16'h0001 << 14);
    run(100);
    keys = '0;
    run(60);
    keys = 16'h0001 << 14;
    run(120);
    exp_q = '{49, 209};
    check_pulses("repress14", 14);

    // reset in the middle of debouncing, then a fresh full debounce
    start(16'h0001 << 5);
    run(30);
    rst_n = 1'b0;
    #1;
    chk("midrst_col", int'(col), 1);
    chk("midrst_valid", int'(key_valid), 0);
    chk("midrst_held", int'(key_held), 0);
    chk("midrst_code", int'(key_code), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pulses.delete();
    codes.delete();
    run(60);
    exp_q = '{49};
    check_pulses("afterrst5", 5);

    // scan_en low while held
    chk("en_held_before", int'(key_held), 1);
    scan_en = 1'b0;
    run(1);
    chk("en_off_col", int'(col), 0);
    chk("en_off_held", int'(key_held), 0);
    chk("en_off_code", int'(key_code), 5);
    run(5);
    scan_en = 1'b1;
    run(1);
    chk("en_on_col", int'(col), 1);
    run(20);

    // randomized key sessions, enable toggles and one reset
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) keys = 16'h0001 << $urandom_range(0, 15);
      else if (r < 75) keys = '0;
      else if (r < 88) keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      else scan_en = ($urandom_range(0, 2) != 0);
      if (i == 30) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      run($urandom_range(10, 150));
      if (i % 10 == 9) scan_en = 1'b1;
    end
    scan_en = 1'b1;
    keys = '0;
    run(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
